// File: rtl/svf_pkg.sv
// Shared types and helpers for the time-multiplexed state-variable filter engine.
package svf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL_Q,
    MUL_F,
    MUL_H,
    WRITE,
    DONE
  } svf_state_e;

  localparam int unsigned MUL_W   = 18;
  localparam int unsigned PROD_W  = 36;
  localparam int unsigned Q_SHIFT = 16;
  localparam int unsigned F_SHIFT = 17;

  // Stored filter state carries three guard bits above the sample width.
  function automatic int unsigned svf_state_w(input int unsigned sample_bits);
    return sample_bits + 3;
  endfunction

  // Saturate a sign-extended state value to the signed sample range.
  function automatic logic signed [MUL_W-1:0] svf_clamp(input logic signed [MUL_W-1:0] x,
                                                        input int unsigned sample_bits);
    logic signed [MUL_W-1:0] hi;
    logic signed [MUL_W-1:0] lo;
    hi = 18'sd1 <<< (sample_bits - 1);
    hi = hi - 18'sd1;
    lo = ~hi;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/svf_voice_scheduler_if.sv
// Bus bundle between the voice source, the filter engine and the output mixer.
interface svf_voice_scheduler_if #(
  parameter int SAMPLE_BITS = 12,
  parameter int VOICES      = 4
);

  logic                            sample_clk;
  logic [VOICES*SAMPLE_BITS-1:0]   in;
  logic [VOICES*18-1:0]            F;
  logic [VOICES*18-1:0]            Q1;
  logic [VOICES*SAMPLE_BITS-1:0]   out_highpass;
  logic [VOICES*SAMPLE_BITS-1:0]   out_lowpass;
  logic [VOICES*SAMPLE_BITS-1:0]   out_bandpass;
  logic [VOICES*SAMPLE_BITS-1:0]   out_notch;
  logic                            out_valid;
  logic                            busy;
  logic                            overrun;

  modport master (
    output sample_clk, in, F, Q1,
    input  out_highpass, out_lowpass, out_bandpass, out_notch, out_valid, busy, overrun
  );

  modport slave (
    input  sample_clk, in, F, Q1,
    output out_highpass, out_lowpass, out_bandpass, out_notch, out_valid, busy, overrun
  );

endinterface

// File: rtl/svf_voice_scheduler_smul_18x18.sv
// Shared signed 18x18 -> 36 combinational multiplier.
module smul_18x18 (
  input  logic signed [17:0] a_i,
  input  logic signed [17:0] b_i,
  output logic signed [35:0] p_o
);

  assign p_o = 36'(a_i) * 36'(b_i);

endmodule

// File: rtl/svf_voice_scheduler.sv
// Chamberlin SVF engine: VOICES channels sequenced through one multiplier per sample frame.
module svf_voice_scheduler #(
  parameter int SAMPLE_BITS = 12,
  parameter int VOICES      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  svf_voice_scheduler_if.slave   bus
);

  import svf_pkg::*;

  localparam int unsigned SW = svf_state_w(SAMPLE_BITS);
  localparam int unsigned VW = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [VW-1:0] LAST_VOICE = VW'(VOICES - 1);

  svf_state_e                    state_q;
  logic [VW-1:0]                 voice_q;
  logic                          prev_q;
  logic                          busy_q;
  logic                          valid_q;
  logic                          overrun_q;
  logic                          start;

  logic signed [SAMPLE_BITS-1:0] in_snap_q [VOICES];
  logic signed [MUL_W-1:0]       f_snap_q  [VOICES];
  logic signed [MUL_W-1:0]       q_snap_q  [VOICES];

  logic signed [SW-1:0]          lp_q    [VOICES];
  logic signed [SW-1:0]          bp_q    [VOICES];
  logic signed [SW-1:0]          hp_q    [VOICES];
  logic signed [SW-1:0]          notch_q [VOICES];

  logic signed [SW-1:0]          qbp_q, lpn_q, hpn_q, bpn_q, notchn_q;
  logic signed [SW-1:0]          qbp_d, lpn_d, hpn_d, bpn_d, notch_d;
  logic signed [SW-1:0]          in_ext;
  logic signed [MUL_W-1:0]       mul_a, mul_b;
  logic signed [PROD_W-1:0]      prod;
  logic                          prod_unused;

  assign start = bus.sample_clk & ~prev_q;

  smul_18x18 u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (prod)
  );

  // Arithmetic shift then truncation to SW bits is a plain bit-slice of the product.
  assign prod_unused = ^{prod[Q_SHIFT-1:0], prod[PROD_W-1:F_SHIFT+SW]};

  // Operand selection for the shared multiplier and the per-step adders.
  always_comb begin
    mul_a  = '0;
    mul_b  = '0;
    case (state_q)
      MUL_Q: begin
        mul_a = 18'(bp_q[voice_q]);
        mul_b = q_snap_q[voice_q];
      end
      MUL_F: begin
        mul_a = 18'(bp_q[voice_q]);
        mul_b = f_snap_q[voice_q];
      end
      MUL_H: begin
        mul_a = 18'(hpn_q);
        mul_b = f_snap_q[voice_q];
      end
      default: ;
    endcase
    in_ext  = SW'(in_snap_q[voice_q]);
    qbp_d   = prod[Q_SHIFT +: SW];
    lpn_d   = lp_q[voice_q] + prod[F_SHIFT +: SW];
    hpn_d   = in_ext - lpn_d - qbp_q;
    bpn_d   = bp_q[voice_q] + prod[F_SHIFT +: SW];
    notch_d = hpn_q + lpn_q;
  end

  // Frame sequencer, per-voice state update and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      voice_q   <= '0;
      prev_q    <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      qbp_q     <= '0;
      lpn_q     <= '0;
      hpn_q     <= '0;
      bpn_q     <= '0;
      notchn_q  <= '0;
      for (int unsigned v = 0; v < VOICES; v++) begin
        in_snap_q[v] <= '0;
        f_snap_q[v]  <= '0;
        q_snap_q[v]  <= '0;
        lp_q[v]      <= '0;
        bp_q[v]      <= '0;
        hp_q[v]      <= '0;
        notch_q[v]   <= '0;
      end
    end else begin
      prev_q <= bus.sample_clk;
      if (start && state_q != IDLE) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int unsigned v = 0; v < VOICES; v++) begin
              in_snap_q[v] <= bus.in[v*SAMPLE_BITS +: SAMPLE_BITS];
              f_snap_q[v]  <= bus.F[v*18 +: 18];
              q_snap_q[v]  <= bus.Q1[v*18 +: 18];
            end
            voice_q <= '0;
            busy_q  <= 1'b1;
            state_q <= MUL_Q;
          end
        end
        MUL_Q: begin
          qbp_q   <= qbp_d;
          state_q <= MUL_F;
        end
        MUL_F: begin
          lpn_q   <= lpn_d;
          hpn_q   <= hpn_d;
          state_q <= MUL_H;
        end
        MUL_H: begin
          bpn_q    <= bpn_d;
          notchn_q <= notch_d;
          state_q  <= WRITE;
        end
        WRITE: begin
          lp_q[voice_q]    <= lpn_q;
          bp_q[voice_q]    <= bpn_q;
          hp_q[voice_q]    <= hpn_q;
          notch_q[voice_q] <= notchn_q;
          if (voice_q == LAST_VOICE) begin
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            voice_q <= voice_q + VW'(1);
            state_q <= MUL_Q;
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

  // Output slices are the clamped stored state, so they change exactly when a voice is written.
  for (genvar v = 0; v < VOICES; v++) begin : g_out
    logic signed [MUL_W-1:0] hp_c, lp_c, bp_c, n_c;
    logic                    clamp_unused;

    // Saturate this voice's stored state to the sample range.
    always_comb begin
      hp_c = svf_clamp(18'(hp_q[v]), SAMPLE_BITS);
      lp_c = svf_clamp(18'(lp_q[v]), SAMPLE_BITS);
      bp_c = svf_clamp(18'(bp_q[v]), SAMPLE_BITS);
      n_c  = svf_clamp(18'(notch_q[v]), SAMPLE_BITS);
    end

    assign clamp_unused = ^{hp_c[MUL_W-1:SAMPLE_BITS], lp_c[MUL_W-1:SAMPLE_BITS],
                            bp_c[MUL_W-1:SAMPLE_BITS], n_c[MUL_W-1:SAMPLE_BITS]};

    assign bus.out_highpass[v*SAMPLE_BITS +: SAMPLE_BITS] = hp_c[SAMPLE_BITS-1:0];
    assign bus.out_lowpass[v*SAMPLE_BITS +: SAMPLE_BITS]  = lp_c[SAMPLE_BITS-1:0];
    assign bus.out_bandpass[v*SAMPLE_BITS +: SAMPLE_BITS] = bp_c[SAMPLE_BITS-1:0];
    assign bus.out_notch[v*SAMPLE_BITS +: SAMPLE_BITS]    = n_c[SAMPLE_BITS-1:0];
  end

endmodule

// File: doc/svf_voice_scheduler.md
# svf_voice_scheduler

Time-multiplexed state-variable filter engine that runs VOICES independent Chamberlin SVF channels through one shared 18x18 signed multiplier. It holds per-voice filter state, and on each rising edge of the sample clock it sequences every voice through the multiply/accumulate steps in turn. It then publishes clamped highpass/lowpass/bandpass/notch outputs for all voices. It sits between the per-voice oscillator/mixer stage and the output mixer, replacing one filter instance per voice.

## Interface
- SAMPLE_BITS, 12: signed sample width; legal range 4..15, so that state (SAMPLE_BITS+3) fits an 18-bit multiplier operand.
- VOICES, 4: number of filter channels; legal range 1..16.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- sample_clk  in  1  sample-rate strobe, synchronous to clk; a frame starts on its 0->1 transition.
- in  in  VOICES*SAMPLE_BITS  packed signed inputs, voice v at [v*SAMPLE_BITS +: SAMPLE_BITS].
- F  in  VOICES*18  packed signed 1.17 frequency coefficients.
- Q1  in  VOICES*18  packed signed 2.16 damping coefficients (1/Q).
- out_highpass, out_lowpass, out_bandpass, out_notch  out  VOICES*SAMPLE_BITS each  packed signed, clamped results.
- out_valid  out  1  one-cycle pulse: all voices of the frame have been updated.
- busy  out  1  high while a frame is in progress.
- overrun  out  1  sticky: a sample_clk edge arrived while busy.

## Operation
- Edge detect: registered prev_sample_clk; start = sample_clk & !prev_sample_clk.
- On start while IDLE: snapshot in, F and Q1 for all voices into frame registers; voice counter = 0; go to MUL_Q. Coefficients changing mid-frame have no effect.
- Per-voice states, in order (lp/bp/hp are the voice's stored state):
  - MUL_Q: mult = bp*Q1, qbp = mult>>>16.
  - MUL_F: mult = bp*F; lp' = lp + (mult>>>17); hp = in - lp' - qbp.
  - MUL_H: mult = hp*F; bp' = bp + (mult>>>17); notch = hp + lp'.
  - WRITE: store lp', bp', hp and notch; write the clamped values into this voice's output slices. If voice = VOICES-1, go to DONE; otherwise increment the voice counter and go to MUL_Q.
- DONE: out_valid=1 for one cycle, busy=0, go to IDLE.
- Arithmetic:
  - Stored state width is SAMPLE_BITS+3, signed.
  - Multiplier operands are sign-extended to 18 bits; the product is 36 bits.
  - The shifted product is truncated to SAMPLE_BITS+3 bits, and adds wrap at that width.
  - Clamp to [-(2^(SAMPLE_BITS-1)), 2^(SAMPLE_BITS-1)-1] is applied only on output.
- Overrun: a start seen while not IDLE is ignored, the frame continues unaffected, and overrun is set to 1. Only rst clears overrun.
- Reset values:
  - All filter state, snapshots, outputs, out_valid, busy, overrun, prev_sample_clk and the voice counter are 0.
  - The FSM returns to IDLE.
- Reset mid-frame aborts immediately. Partially updated voices are cleared; there is no resume.

## Timing
- Start detected at posedge T0: busy=1 from T0, voice v occupies T0+4v .. T0+4v+3.
- Output slices for voice v change at posedge T0+4v+4.
- At posedge T0+4*VOICES: busy falls and out_valid rises; out_valid falls at the next posedge.
- Minimum sample_clk period is 4*VOICES+1 clk cycles; shorter periods cause an overrun.
- sample_clk held high does not retrigger. A start coincident with DONE is an overrun (FSM not IDLE).
- The multiplier is combinational between registered operands and the state-register capture: one clk of logic depth.

## Structure
- Package svf_pkg:
  - FSM state enum (IDLE, MUL_Q, MUL_F, MUL_H, WRITE, DONE).
  - Q_SHIFT=16 and F_SHIFT=17.
  - Function svf_state_w(SAMPLE_BITS) = SAMPLE_BITS+3.
  - Saturating clamp function.
- Single sub-module smul_18x18 (signed 18x18 -> 36, combinational), instantiated exactly once. Per-voice state is held in register arrays indexed by the voice counter.

## Test plan
- Reset: assert rst mid-idle -> all outputs 0, busy=0, overrun=0, out_valid=0.
- Bypass, VOICES=4, all F=0, Q1=0, in=100 -> after one frame each voice: hp=100, notch=100, lp=0, bp=0. out_valid pulses exactly at T0+16.
- DC convergence: voice0 F=18'h10000 (0.5), Q1=18'h10000 (1.0), in=1000; other voices in=0 -> after 200 frames voice0 lowpass=1000±2, bandpass/highpass within ±2 of 0; voices 1-3 all outputs stay 0.
- Clamp: voice0 in=2047, F=18'h11999 (~0.55), Q1=0 for 500 frames -> every output sample within [-2048, 2047]; no wrap glitch at the clamp boundary.
- Overrun: second sample_clk rising edge at T0+5 -> ignored, overrun=1 from T0+6 onward, first frame completes with out_valid at T0+16.
- Async reset at T0+6 mid-frame -> busy=0 and all outputs 0 immediately. The next start runs voice 0 from zero state with results identical to the bypass case.
